// File: rtl/mfp_seven_segment_scanner_pkg.sv
// Shared constants for the 7-segment scanner.
//   MFP_7_SEGMENT_HEX_WIDTH : width of the IO_7_SegmentHEX register (8 nibbles)
//   SEG_TABLE               : active-low {g,f,e,d,c,b,a} patterns for hex 0..F
//   SEG_OFF                 : all segments dark
package mfp_seven_segment_scanner_pkg;

  localparam int MFP_7_SEGMENT_HEX_WIDTH = 32;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/mfp_hex_to_seven_segment.sv
// Combinational hex nibble to active-low 7-segment decoder.
//   i_nibble : 4-bit hex value
//   o_seg_n  : segments {g,f,e,d,c,b,a}, active-low
module mfp_hex_to_seven_segment
  import mfp_seven_segment_scanner_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = SEG_TABLE[i_nibble];

endmodule

// File: rtl/mfp_seven_segment_scanner.sv
// Time-multiplexed common-anode 7-segment display scanner.
// Each digit slot begins with an all-dark anti-ghosting interval, then lights
// the selected digit. Display data is snapshotted once per frame so bus writes
// never tear a frame. Supports leading-zero suppression and per-digit dots.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   hex_value     : one nibble per digit, digit 0 rightmost
//   dot           : decimal point request per digit (1 = lit)
//   digit_mask    : 1 = digit enabled
//   lz_blank      : 1 = suppress leading zeros (digit 0 always shown)
//   anode_n       : digit select, active-low, at most one bit low
//   seg_n         : segments {g..a}, active-low
//   dp_n          : decimal point, active-low
//   frame_start   : one-cycle pulse when a new snapshot is taken
module mfp_seven_segment_scanner
  import mfp_seven_segment_scanner_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 16384,
  parameter int BLANK_CYCLES = 256
)
(
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [4*N_DIGITS-1:0] hex_value,
  input  logic [N_DIGITS-1:0]   dot,
  input  logic [N_DIGITS-1:0]   digit_mask,
  input  logic                  lz_blank,
  output logic [N_DIGITS-1:0]   anode_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_MAX = DW'(N_DIGITS - 1);

  logic [CW-1:0]         r_cnt;
  logic [DW-1:0]         r_digit;
  logic [4*N_DIGITS-1:0] r_hex_frame;
  logic [N_DIGITS-1:0]   r_dot_frame;
  logic [N_DIGITS-1:0]   r_mask_frame;
  logic                  r_lz_frame;

  logic                  w_snap;
  logic [4*N_DIGITS-1:0] w_hex;
  logic [N_DIGITS-1:0]   w_dot;
  logic [N_DIGITS-1:0]   w_mask;
  logic                  w_lz;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg_n;
  logic [DW-1:0]         w_top_nz;
  logic                  w_blank;
  logic                  w_dark;
  logic                  w_lit;
  logic [N_DIGITS-1:0]   w_anode_sel_n;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt   <= '0;
      r_digit <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_digit <= (r_digit == DIG_MAX) ? '0 : r_digit + 1'b1;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign w_snap = (r_cnt == '0) && (r_digit == '0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hex_frame  <= '0;
      r_dot_frame  <= '0;
      r_mask_frame <= '0;
      r_lz_frame   <= 1'b0;
    end else if (w_snap) begin
      r_hex_frame  <= hex_value;
      r_dot_frame  <= dot;
      r_mask_frame <= digit_mask;
      r_lz_frame   <= lz_blank;
    end
  end

  // In the snapshot cycle the frame registers still hold the old frame, so
  // decode straight from the inputs being latched; otherwise the first slot
  // of a frame would show stale data when BLANK_CYCLES is 0.
  assign w_hex  = w_snap ? hex_value  : r_hex_frame;
  assign w_dot  = w_snap ? dot        : r_dot_frame;
  assign w_mask = w_snap ? digit_mask : r_mask_frame;
  assign w_lz   = w_snap ? lz_blank   : r_lz_frame;

  assign w_nibble = w_hex[{r_digit, 2'b00} +: 4];

  mfp_hex_to_seven_segment u_dec (
    .i_nibble (w_nibble),
    .o_seg_n  (w_seg_n)
  );

  // Index of the highest nonzero nibble; 0 when all nibbles are zero, which
  // keeps digit 0 visible under leading-zero suppression.
  always_comb begin
    w_top_nz = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_hex[4*i +: 4] != 4'h0) w_top_nz = DW'(i);
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_cnt < CW'(BLANK_CYCLES));
    end
  endgenerate

  assign w_dark        = !w_mask[r_digit] || (w_lz && (r_digit > w_top_nz));
  assign w_lit         = !w_blank && !w_dark;
  assign w_anode_sel_n = ~(N_DIGITS'(1) << r_digit);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      anode_n     <= '1;
      seg_n       <= SEG_OFF;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      anode_n     <= w_lit ? w_anode_sel_n : '1;
      seg_n       <= w_lit ? w_seg_n : SEG_OFF;
      dp_n        <= w_lit ? ~w_dot[r_digit] : 1'b1;
      frame_start <= w_snap;
    end
  end

endmodule

// File: tb/tb_mfp_seven_segment_scanner.sv
module tb_mfp_seven_segment_scanner;

  localparam int SD = 8;   // slot length
  localparam int BC = 3;   // blank cycles per slot
  localparam int FR = 64;  // frame length

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] hex_value = '0;
  logic [7:0]  dot = '0;
  logic [7:0]  digit_mask = '1;
  logic        lz_blank = 1'b0;
  logic [7:0]  anode_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_start;

  int n_pass = 0;
  int n_total = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [7:0] cap_an  [FR];
  logic [6:0] cap_seg [FR];
  logic       cap_dp  [FR];
  logic       cap_fs  [FR];

  mfp_seven_segment_scanner #(
    .N_DIGITS     (8),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .hex_value   (hex_value),
    .dot         (dot),
    .digit_mask  (digit_mask),
    .lz_blank    (lz_blank),
    .anode_n     (anode_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  always #5 HCLK = ~HCLK;

  function automatic int count_low(input logic [7:0] a);
    int c = 0;
    for (int i = 0; i < 8; i++) if (a[i] == 1'b0) c++;
    return c;
  endfunction

  // Advance at least one negedge, then find the next frame_start sample.
  task automatic wait_frame_start();
    int budget = 0;
    @(negedge HCLK);
    while (frame_start !== 1'b1 && budget < 200) begin
      @(negedge HCLK);
      budget++;
    end
    n_total++;
    if (frame_start !== 1'b1)
      $display("FAIL frame_sync: frame_start=%b required 1 within 200 cycles", frame_start);
    else
      n_pass++;
  endtask

  // Record one full frame starting at the frame_start sample (index 0).
  task automatic capture_frame(input logic chg, input logic [31:0] newval);
    wait_frame_start();
    for (int k = 0; k < FR; k++) begin
      cap_an[k]  = anode_n;
      cap_seg[k] = seg_n;
      cap_dp[k]  = dp_n;
      cap_fs[k]  = frame_start;
      if (chg && k == 26) hex_value = newval;  // during digit 3
      if (k < FR - 1) @(negedge HCLK);
    end
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if (anode_n !== 8'hFF) $display("FAIL reset_anode: got %h required ff", anode_n);
    else n_pass++;
    n_total++;
    if (seg_n !== 7'h7F) $display("FAIL reset_seg: got %h required 7f", seg_n);
    else n_pass++;
    n_total++;
    if (dp_n !== 1'b1) $display("FAIL reset_dp: got %b required 1", dp_n);
    else n_pass++;
    n_total++;
    if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b required 0", frame_start);
    else n_pass++;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    n_total++;
    if (frame_start !== 1'b1 || anode_n !== 8'hFF)
      $display("FAIL reset_first_frame: fs=%b anode=%h required fs=1 anode=ff", frame_start, anode_n);
    else n_pass++;
  endtask

  task automatic check_sweep(input int base);
    for (int d = 0; d < 8; d++) begin
      logic ok = 1'b1;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      for (int c = 0; c < SD; c++) begin
        int k = d * SD + c;
        exp_an  = (c < BC) ? 8'hFF : ~(8'h01 << d);
        exp_seg = (c < BC) ? 7'h7F : seg_tbl[base + d];
        if (ok && (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg)) begin
          ok = 1'b0;
          $display("FAIL sweep_digit%0d_%0d: k=%0d anode=%h seg=%b required anode=%h seg=%b",
                   d, base, k, cap_an[k], cap_seg[k], exp_an, exp_seg);
        end
      end
      n_total++;
      if (ok) n_pass++;
    end
  endtask

  task automatic test_decoder_sweep();
    digit_mask = 8'hFF; dot = 8'h00; lz_blank = 1'b0;
    hex_value = 32'h76543210;
    capture_frame(1'b0, 32'h0);
    check_sweep(0);
    hex_value = 32'hFEDCBA98;
    capture_frame(1'b0, 32'h0);
    check_sweep(8);
  endtask

  // Uses the frame captured by the previous test (all digits enabled).
  task automatic test_anti_ghost();
    logic ok_two = 1'b1;
    logic ok_fs  = 1'b1;
    for (int d = 0; d < 8; d++) begin
      int nb = 0;
      int nl = 0;
      for (int c = 0; c < SD; c++) begin
        if (c < BC && cap_an[d*SD + c] === 8'hFF) nb++;
        if (c >= BC && count_low(cap_an[d*SD + c]) == 1) nl++;
      end
      n_total++;
      if (nb != 3 || nl != 5)
        $display("FAIL ghost_slot%0d: blank=%0d lit=%0d required blank=3 lit=5", d, nb, nl);
      else n_pass++;
    end
    for (int k = 0; k < FR; k++) begin
      if (ok_two && count_low(cap_an[k]) > 1) begin
        ok_two = 1'b0;
        $display("FAIL ghost_two_low: k=%0d anode=%h required at most one low", k, cap_an[k]);
      end
      if (ok_fs && cap_fs[k] !== (k == 0)) begin
        ok_fs = 1'b0;
        $display("FAIL frame_pulse: k=%0d fs=%b required %b", k, cap_fs[k], (k == 0));
      end
    end
    n_total++;
    if (ok_two) n_pass++;
    n_total++;
    if (ok_fs) n_pass++;
  endtask

  // lit_mask: digits expected lit; segs: expected nibble per lit digit.
  task automatic check_lit(input string nm, input logic [7:0] lit_mask, input logic [31:0] val);
    for (int d = 0; d < 8; d++) begin
      logic ok = 1'b1;
      for (int c = BC; c < SD; c++) begin
        int k = d * SD + c;
        logic [7:0] ea = lit_mask[d] ? ~(8'h01 << d) : 8'hFF;
        logic [6:0] es = lit_mask[d] ? seg_tbl[(val >> (4*d)) & 32'hF] : 7'h7F;
        if (ok && (cap_an[k] !== ea || cap_seg[k] !== es)) begin
          ok = 1'b0;
          $display("FAIL %s_digit%0d: anode=%h seg=%b required anode=%h seg=%b",
                   nm, d, cap_an[k], cap_seg[k], ea, es);
        end
      end
      n_total++;
      if (ok) n_pass++;
    end
  endtask

  task automatic test_leading_zeros();
    lz_blank = 1'b1;
    hex_value = 32'h000000A0;
    capture_frame(1'b0, 32'h0);
    check_lit("lz_a0", 8'b0000_0011, 32'h000000A0);
    hex_value = 32'h00000000;
    capture_frame(1'b0, 32'h0);
    check_lit("lz_zero", 8'b0000_0001, 32'h00000000);
    lz_blank = 1'b0;
  endtask

  task automatic test_tear_free();
    logic ok;
    hex_value = 32'h11111111;
    capture_frame(1'b1, 32'h22222222);
    ok = 1'b1;
    for (int k = 0; k < FR; k++)
      if (ok && (k % SD) >= BC && cap_seg[k] !== seg_tbl[1]) begin
        ok = 1'b0;
        $display("FAIL tear_old_frame: k=%0d seg=%b required %b", k, cap_seg[k], seg_tbl[1]);
      end
    n_total++;
    if (ok) n_pass++;
    capture_frame(1'b0, 32'h0);
    ok = 1'b1;
    for (int k = 0; k < FR; k++)
      if (ok && (k % SD) >= BC && cap_seg[k] !== seg_tbl[2]) begin
        ok = 1'b0;
        $display("FAIL tear_new_frame: k=%0d seg=%b required %b", k, cap_seg[k], seg_tbl[2]);
      end
    n_total++;
    if (ok) n_pass++;
  endtask

  task automatic test_mask_dot();
    hex_value = 32'h76543210;
    digit_mask = 8'h0F;
    dot = 8'h05;
    capture_frame(1'b0, 32'h0);
    for (int d = 0; d < 8; d++) begin
      logic ok = 1'b1;
      for (int c = 0; c < SD; c++) begin
        int k = d * SD + c;
        logic lit = (c >= BC) && (d < 4);
        logic [7:0] ea = lit ? ~(8'h01 << d) : 8'hFF;
        logic ed = !(lit && (d == 0 || d == 2));
        if (ok && (cap_an[k] !== ea || cap_dp[k] !== ed)) begin
          ok = 1'b0;
          $display("FAIL maskdot_digit%0d: k=%0d anode=%h dp=%b required anode=%h dp=%b",
                   d, k, cap_an[k], cap_dp[k], ea, ed);
        end
      end
      n_total++;
      if (ok) n_pass++;
    end
    digit_mask = 8'hFF;
    dot = 8'h00;
  endtask

  task automatic test_async_reset();
    int first_lit = -1;
    wait_frame_start();
    for (int k = 0; k < 5 * SD + 4; k++) @(negedge HCLK);
    n_total++;
    if (anode_n !== 8'hDF) $display("FAIL rst_pre_digit5: anode=%h required df", anode_n);
    else n_pass++;
    #2 HRESETn = 1'b0;
    #1;
    n_total++;
    if (anode_n !== 8'hFF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_start !== 1'b0)
      $display("FAIL rst_async: anode=%h seg=%h dp=%b fs=%b required ff 7f 1 0",
               anode_n, seg_n, dp_n, frame_start);
    else n_pass++;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    n_total++;
    if (frame_start !== 1'b1) $display("FAIL rst_restart_fs: fs=%b required 1", frame_start);
    else n_pass++;
    for (int k = 0; k < SD && first_lit < 0; k++) begin
      if (anode_n !== 8'hFF) first_lit = k;
      else @(negedge HCLK);
    end
    n_total++;
    if (first_lit != BC || anode_n !== 8'hFE)
      $display("FAIL rst_first_lit: at k=%0d anode=%h required k=3 anode=fe", first_lit, anode_n);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_decoder_sweep();
    test_anti_ghost();
    test_leading_zeros();
    test_tear_free();
    test_mask_dot();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
